// File: rtl/spi_pkg.sv
// Shared SPI frame definitions: responder state encoding and frame geometry,
// used by both the responder and the initiator side.
package spi_pkg;

    localparam int FRAME_BITS  = 16;
    localparam int HEADER_BITS = 8;
    localparam int RW_BIT      = 15;
    localparam int ADDR_W      = 7;
    localparam int DATA_W      = 8;

    typedef enum logic [2:0] {
        ST_WAITHIGH = 3'd0,
        ST_IDLE     = 3'd1,
        ST_HEADER   = 3'd2,
        ST_WRITE    = 3'd3,
        ST_RDFETCH  = 3'd4,
        ST_READ     = 3'd5,
        ST_DRAIN    = 3'd6
    } spi_state_e;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous input, with single-cycle
// rise/fall pulses aligned to the synchronized output.
module spi_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] chain_q;
    logic              prev_q;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            chain_q <= {STAGES{RESET_VAL}};
            prev_q  <= RESET_VAL;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], i_async};
            prev_q  <= chain_q[STAGES-1];
        end
    end

    assign o_sync = chain_q[STAGES-1];
    assign o_rise = chain_q[STAGES-1] & ~prev_q;
    assign o_fall = ~chain_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_responder.sv
// SPI mode-0 register responder: 16-bit frames {R/W, addr[6:0], data[7:0]},
// MSB first, decoded into single-cycle register read/write strobes.
module spi_responder
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int SCK_MIN_HALF = 3
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_sen,
    input  logic              i_sck,
    input  logic              i_sdat,
    output logic              o_sout,
    output logic [ADDR_W-1:0] o_regAddr,
    output logic [DATA_W-1:0] o_regWrData,
    output logic              o_regWrStrobe,
    output logic              o_regRdStrobe,
    input  logic [DATA_W-1:0] i_regRdData,
    output logic              o_busy,
    output logic              o_frameError,
    output spi_state_e        o_state
);

    localparam bit         PARAMS_OK    = (SYNC_STAGES >= 2) && (SCK_MIN_HALF >= 3);
    localparam logic [3:0] CNT_START    = 4'(FRAME_BITS - 1);
    localparam logic [3:0] CNT_HDR_LAST = 4'(FRAME_BITS - HEADER_BITS);
    localparam logic [7:0] WAIT_LAST    = 8'(SYNC_STAGES);
    localparam int         RW_IDX       = RW_BIT - HEADER_BITS - 1;

    if (!PARAMS_OK) begin : g_bad_params
        $error("spi_responder: SYNC_STAGES must be >= 2 and SCK_MIN_HALF >= 3");
    end

    logic sen_sync, sen_rise, sen_fall;
    logic sck_sync, sck_rise, sck_fall;
    logic sdat_sync, sdat_rise_unused, sdat_fall_unused;
    logic sync_unused;

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_sen (
        .i_clock(i_clock), .i_reset(i_reset), .i_async(i_sen),
        .o_sync(sen_sync), .o_rise(sen_rise), .o_fall(sen_fall)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
        .i_clock(i_clock), .i_reset(i_reset), .i_async(i_sck),
        .o_sync(sck_sync), .o_rise(sck_rise), .o_fall(sck_fall)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sdat (
        .i_clock(i_clock), .i_reset(i_reset), .i_async(i_sdat),
        .o_sync(sdat_sync), .o_rise(sdat_rise_unused), .o_fall(sdat_fall_unused)
    );

    assign sync_unused = &{1'b0, sck_sync, sdat_rise_unused, sdat_fall_unused};

    spi_state_e        state_q;
    logic [3:0]        cnt_q;
    logic [7:0]        wait_q;
    logic [DATA_W-1:0] rx_q;
    logic [DATA_W-1:0] tx_q;
    logic              fetch_cap_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic              wr_stb_q;
    logic              rd_stb_q;
    logic              err_q;

    // Register-side protocol: each strobe is a one-cycle request with no
    // back-pressure; o_regWrData is meaningful while o_regWrStrobe is high,
    // and i_regRdData must be valid exactly one cycle after o_regRdStrobe.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q     <= ST_WAITHIGH;
            cnt_q       <= '0;
            wait_q      <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            fetch_cap_q <= 1'b0;
            addr_q      <= '0;
            wr_data_q   <= '0;
            wr_stb_q    <= 1'b0;
            rd_stb_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            wr_stb_q <= 1'b0;
            rd_stb_q <= 1'b0;
            err_q    <= 1'b0;
            case (state_q)
                // Hold off until the synchronizers carry real samples, so a
                // frame already running at reset is never seen as a fresh start.
                ST_WAITHIGH: begin
                    if (wait_q != WAIT_LAST) begin
                        wait_q <= wait_q + 8'd1;
                    end else if (sen_sync) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (sen_fall) begin
                        state_q <= ST_HEADER;
                        cnt_q   <= CNT_START;
                    end
                end
                ST_HEADER: begin
                    if (sen_rise) begin
                        state_q <= ST_IDLE;
                        err_q   <= 1'b1;
                    end else if (sck_rise) begin
                        rx_q  <= {rx_q[DATA_W-2:0], sdat_sync};
                        cnt_q <= cnt_q - 4'd1;
                        if (cnt_q == CNT_HDR_LAST) begin
                            addr_q <= {rx_q[ADDR_W-2:0], sdat_sync};
                            if (rx_q[RW_IDX]) begin
                                state_q     <= ST_RDFETCH;
                                rd_stb_q    <= 1'b1;
                                fetch_cap_q <= 1'b0;
                            end else begin
                                state_q <= ST_WRITE;
                            end
                        end
                    end
                end
                ST_WRITE: begin
                    if (sen_rise) begin
                        state_q <= ST_IDLE;
                        err_q   <= 1'b1;
                    end else if (sck_rise) begin
                        rx_q  <= {rx_q[DATA_W-2:0], sdat_sync};
                        cnt_q <= cnt_q - 4'd1;
                        if (cnt_q == 4'd0) begin
                            wr_data_q <= {rx_q[DATA_W-2:0], sdat_sync};
                            wr_stb_q  <= 1'b1;
                            state_q   <= ST_DRAIN;
                        end
                    end
                end
                ST_RDFETCH: begin
                    if (sen_rise) begin
                        state_q     <= ST_IDLE;
                        err_q       <= 1'b1;
                        fetch_cap_q <= 1'b0;
                    end else if (!fetch_cap_q) begin
                        fetch_cap_q <= 1'b1;
                    end else begin
                        tx_q        <= i_regRdData;
                        fetch_cap_q <= 1'b0;
                        state_q     <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (sen_rise) begin
                        state_q <= ST_IDLE;
                        err_q   <= 1'b1;
                    end else if (sck_rise) begin
                        cnt_q <= cnt_q - 4'd1;
                        if (cnt_q == 4'd0) begin
                            state_q <= ST_DRAIN;
                        end
                    end else if (sck_fall && cnt_q != CNT_HDR_LAST - 4'd1) begin
                        // The fall right after the 8th rise must keep bit 7 on the line.
                        tx_q <= {tx_q[DATA_W-2:0], 1'b0};
                    end
                end
                ST_DRAIN: begin
                    if (sen_rise) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_WAITHIGH;
            endcase
        end
    end

    always_comb begin
        o_sout = 1'b0;
        if (state_q == ST_READ) begin
            o_sout = tx_q[DATA_W-1];
        end else if (state_q == ST_RDFETCH && fetch_cap_q) begin
            o_sout = i_regRdData[DATA_W-1];
        end
    end

    assign o_regAddr     = addr_q;
    assign o_regWrData   = wr_data_q;
    assign o_regWrStrobe = wr_stb_q;
    assign o_regRdStrobe = rd_stb_q;
    assign o_frameError  = err_q;
    assign o_busy        = ~sen_sync && (state_q != ST_IDLE) && (state_q != ST_WAITHIGH);
    assign o_state       = state_q;

endmodule

// File: tb/tb_spi_responder.sv
// Bench for spi_responder: a table of directed frames, hand-written reset and
// back-to-back sequences, and random frames checked against a frame-level model.
module tb_spi_responder;
    import spi_pkg::*;

    localparam int SYNC_STAGES  = 2;
    localparam int SCK_MIN_HALF = 3;
    localparam int EW           = 17;
    localparam logic [1:0] EV_WR  = 2'd1;
    localparam logic [1:0] EV_RD  = 2'd2;
    localparam logic [1:0] EV_ERR = 2'd3;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, sen, sck, sdat, sout;
    logic [6:0] reg_addr;
    logic [7:0] wr_data, rd_data, rd_val;
    logic       wr_stb, rd_stb, busy, ferr;
    spi_state_e dbg_state;

    spi_responder #(.SYNC_STAGES(SYNC_STAGES), .SCK_MIN_HALF(SCK_MIN_HALF)) dut (
        .i_clock(clk), .i_reset(rst), .i_sen(sen), .i_sck(sck), .i_sdat(sdat),
        .o_sout(sout), .o_regAddr(reg_addr), .o_regWrData(wr_data),
        .o_regWrStrobe(wr_stb), .o_regRdStrobe(rd_stb), .i_regRdData(rd_data),
        .o_busy(busy), .o_frameError(ferr), .o_state(dbg_state)
    );

    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] got_q[$];

    function automatic logic [EW-1:0] ev(input logic [1:0] t, input logic [6:0] a, input logic [7:0] d);
        return {t, a, d};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    // monitor: record register-side events away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            if (wr_stb || rd_stb) begin
                checks++;
                if (wr_stb && rd_stb) begin
                    errors++;
                    $display("FAIL both_strobes got wr=%0b rd=%0b want one", wr_stb, rd_stb);
                end
            end
            if (wr_stb) got_q.push_back(ev(EV_WR, reg_addr, wr_data));
            if (rd_stb) got_q.push_back(ev(EV_RD, reg_addr, 8'h00));
            if (ferr)   got_q.push_back(ev(EV_ERR, 7'h00, 8'h00));
        end
    end

    // register file: read data valid exactly one cycle after the strobe, garbage otherwise
    initial begin
        logic prev_stb;
        prev_stb = 1'b0;
        rd_data  = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            rd_data  = prev_stb ? rd_val : 8'($urandom);
            prev_stb = rd_stb;
        end
    end

    // frame-level reference: what a frame of nrises SCK rises must produce
    task automatic model_frame(input logic [15:0] word, input int nrises);
        logic       rw;
        logic [6:0] a;
        rw = word[15];
        a  = word[14:8];
        if (nrises >= 16) begin
            if (rw) exp_q.push_back(ev(EV_RD, a, 8'h00));
            else    exp_q.push_back(ev(EV_WR, a, word[7:0]));
        end else begin
            if (rw && nrises >= 8) exp_q.push_back(ev(EV_RD, a, 8'h00));
            exp_q.push_back(ev(EV_ERR, 7'h00, 8'h00));
        end
    endtask

    task automatic compare_sb(input string tag);
        check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check({tag, "_event"}, 32'(got_q[i]), 32'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_addr"}, 32'(reg_addr), 32'h0);
        check({tag, "_wrdata"}, 32'(wr_data), 32'h0);
        check({tag, "_sout"}, 32'(sout), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_err"}, 32'(ferr), 32'h0);
        check({tag, "_strobes"}, 32'({wr_stb, rd_stb}), 32'h0);
    endtask

    // initiator driver: mode 0, data set while SCK low, sout sampled at each rise
    task automatic send_frame(input logic [15:0] word, input int nrises, input int half,
                              input int rst_at, output logic [7:0] miso);
        miso = 8'h00;
        sen  = 1'b0;
        for (int k = 0; k < nrises; k++) begin
            sdat = (k < 16) ? word[15-k] : 1'($urandom);
            repeat (half) @(negedge clk);
            if (k >= 8 && k < 16) miso[15-k] = sout;
            sck = 1'b1;
            if (k == 0) check("busy_in_frame", 32'(busy), 32'h1);
            if (k == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                check_reset_outs("midreset");
                @(negedge clk);
                rst = 1'b0;
            end
            repeat (half) @(negedge clk);
            sck = 1'b0;
        end
        repeat (half) @(negedge clk);
        sen  = 1'b1;
        sdat = 1'b0;
    endtask

    typedef struct {
        logic       rw;
        logic [6:0] addr;
        logic [7:0] data;
        logic [7:0] rdval;
        int         nrises;
        int         half;
        int         exp_wr;
        int         exp_rd;
        int         exp_err;
        logic       chk_miso;
        logic [7:0] exp_miso;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [7:0]  miso;
        logic [15:0] word;
        int          nwr, nrd, nerr, n, h;

        vecs[0] = '{1'b0, 7'h15, 8'hA5, 8'h00, 16, 15, 1, 0, 0, 1'b0, 8'h00};
        vecs[1] = '{1'b1, 7'h7F, 8'h00, 8'h3C, 16, 4,  0, 1, 0, 1'b1, 8'h3C};
        vecs[2] = '{1'b0, 7'h33, 8'hC3, 8'h00, 12, 4,  0, 0, 1, 1'b0, 8'h00};
        vecs[3] = '{1'b1, 7'h00, 8'h00, 8'h80, 16, 3,  0, 1, 0, 1'b1, 8'h80};
        vecs[4] = '{1'b0, 7'h2A, 8'h5C, 8'h00, 20, 3,  1, 0, 0, 1'b0, 8'h00};
        vecs[5] = '{1'b1, 7'h11, 8'h00, 8'h77, 10, 5,  0, 1, 1, 1'b0, 8'h00};
        vecs[6] = '{1'b0, 7'h40, 8'hFF, 8'h00, 3,  4,  0, 0, 1, 1'b0, 8'h00};

        rst = 1'b1; sen = 1'b1; sck = 1'b0; sdat = 1'b0; rd_val = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_outs("reset");
        check("reset_state", 32'(dbg_state), 32'(ST_WAITHIGH));
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("idle_state", 32'(dbg_state), 32'(ST_IDLE));
        check("idle_busy", 32'(busy), 32'h0);

        // directed table
        for (int v = 0; v < 7; v++) begin
            rd_val = vecs[v].rdval;
            send_frame({vecs[v].rw, vecs[v].addr, vecs[v].data}, vecs[v].nrises, vecs[v].half, -1, miso);
            repeat (10) @(negedge clk);
            nwr = 0; nrd = 0; nerr = 0;
            foreach (got_q[i]) begin
                if (got_q[i][16:15] == EV_WR) begin
                    nwr++;
                    check("tbl_wr_addr", 32'(got_q[i][14:8]), 32'(vecs[v].addr));
                    check("tbl_wr_data", 32'(got_q[i][7:0]), 32'(vecs[v].data));
                end else if (got_q[i][16:15] == EV_RD) begin
                    nrd++;
                    check("tbl_rd_addr", 32'(got_q[i][14:8]), 32'(vecs[v].addr));
                end else begin
                    nerr++;
                end
            end
            check("tbl_wr_count", 32'(nwr), 32'(vecs[v].exp_wr));
            check("tbl_rd_count", 32'(nrd), 32'(vecs[v].exp_rd));
            check("tbl_err_count", 32'(nerr), 32'(vecs[v].exp_err));
            check("tbl_busy_after", 32'(busy), 32'h0);
            if (vecs[v].nrises >= 8) check("tbl_addr_held", 32'(reg_addr), 32'(vecs[v].addr));
            if (vecs[v].chk_miso) check("tbl_miso", 32'(miso), 32'(vecs[v].exp_miso));
            got_q.delete();
        end

        // reset in the middle of a write, SEN held low to the end of the frame
        send_frame(16'h2199, 16, 4, 4, miso);
        repeat (10) @(negedge clk);
        check("rst_frame_quiet", 32'(got_q.size()), 32'h0);
        got_q.delete();
        send_frame(16'h0A3E, 16, 4, -1, miso);
        model_frame(16'h0A3E, 16);
        repeat (10) @(negedge clk);
        compare_sb("after_reset");

        // back-to-back writes at the minimum SEN-high gap, second one over-clocked
        send_frame(16'h1234, 16, SCK_MIN_HALF, -1, miso);
        model_frame(16'h1234, 16);
        repeat (SYNC_STAGES + 2) @(negedge clk);
        send_frame(16'h55AA, 20, SCK_MIN_HALF, -1, miso);
        model_frame(16'h55AA, 20);
        repeat (10) @(negedge clk);
        compare_sb("b2b");

        // random frames against the model
        for (int r = 0; r < 24; r++) begin
            word   = 16'($urandom);
            rd_val = 8'($urandom);
            n      = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : 16;
            h      = $urandom_range(SCK_MIN_HALF, 8);
            send_frame(word, n, h, -1, miso);
            model_frame(word, n);
            repeat ($urandom_range(6, 12)) @(negedge clk);
            compare_sb("rand");
            if (word[15] && n >= 16) check("rand_miso", 32'(miso), 32'(rd_val));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_responder.md
SPI_RESPONDER -- requirements
Module: spi_responder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the number of synchronizer flops on i_sen, i_sck and i_sdat (minimum 2).
REQ-002 SHALL have parameter SCK_MIN_HALF, default 3, meaning the minimum number of i_clock periods in each SCK high phase and each SCK low phase that the block must support.
REQ-003 i_clock  in  1  system clock; one clock domain for all logic.
REQ-004 i_reset  in  1  reset, synchronous, active-high.
REQ-005 i_sen  in  1  chip select, active low, asynchronous to i_clock.
REQ-006 i_sck  in  1  serial clock, idles low; both sides sample on rising SCK.
REQ-007 i_sdat  in  1  serial data from initiator, MSB first.
REQ-008 o_sout  out  1  serial read data to initiator.
REQ-009 o_regAddr  out  7  register address, held from header completion until the next frame's header completes.
REQ-010 o_regWrData  out  8  write data; valid while o_regWrStrobe is high.
REQ-011 o_regWrStrobe  out  1  one-cycle write pulse.
REQ-012 o_regRdStrobe  out  1  one-cycle read request pulse.
REQ-013 i_regRdData  in  8  read data; valid exactly 1 cycle after o_regRdStrobe.
REQ-014 o_busy  out  1  high while a frame is in progress (synced SEN low and state not IDLE).
REQ-015 o_frameError  out  1  one-cycle pulse when a frame aborts.

Function
REQ-016 Frame layout: bit 15 R/W (1=read, 0=write), bits 14:8 address, bits 7:0 data; all MSB first.
REQ-017 Edges: a falling edge of synced SEN starts a frame; SCK rising/falling edges are detected on synced SCK; i_sdat is taken from the synced sample aligned with the detected rising edge.
REQ-018 States: IDLE, HEADER, WRITE, RDFETCH, READ, DRAIN, plus WAITHIGH for post-reset.
REQ-019 IDLE->HEADER on synced SEN fall; 4-bit bit counter loads 15.
REQ-020 HEADER: shift in one bit per SCK rise; after the 8th rise, latch o_regAddr, then go to WRITE if R/W=0, else to RDFETCH.
REQ-021 WRITE: shift in 8 bits; on the cycle after the 16th rise, assert o_regWrStrobe for 1 cycle with the assembled byte, then go to DRAIN.
REQ-022 RDFETCH: o_regRdStrobe on the cycle after the 8th rise; capture i_regRdData on the following cycle into the tx shift register; drive bit 7 on o_sout in that same cycle; then go to READ.
REQ-023 Read MSB timing: o_sout bit 7 SHALL be valid within SYNC_STAGES+3 cycles of the 8th SCK rise, i.e. before the 9th rise given SCK_MIN_HALF.
REQ-024 READ: on each synced SCK fall, shift so the next bit drives o_sout; after the 16th rise, go to DRAIN.
REQ-025 DRAIN: ignore further SCK edges; synced SEN rise returns the block to IDLE with no further strobes.
REQ-026 Abort: synced SEN rise in HEADER, WRITE, RDFETCH or READ SHALL return the block to IDLE and pulse o_frameError.
REQ-027 Abort side effects: no o_regWrStrobe SHALL occur on abort; an o_regRdStrobe already issued stands.
REQ-028 SEN rise coinciding with the 16th-rise-plus-1 cycle of a write: commit the strobe, then go to IDLE, with no error.
REQ-029 o_sout idle value: 0 whenever state is not READ or the RDFETCH capture cycle.
REQ-030 Back-to-back frames SHALL be accepted when SEN is high for at least SYNC_STAGES+2 cycles between them.
REQ-031 Strobes: at most one strobe per frame; o_regWrStrobe and o_regRdStrobe SHALL never both be high.

Reset
REQ-032 While i_reset is high, all outputs SHALL be 0: o_regAddr=0, o_regWrData=0, o_sout=0, o_busy=0, o_frameError=0, both strobes 0.
REQ-033 On reset, the synchronizers SHALL clear to SEN=1, SCK=0 and SDAT=0.
REQ-034 After reset release, the state SHALL be WAITHIGH until synced SEN is high, then IDLE; a frame in progress at reset SHALL be ignored entirely, with no strobe and no error.

Structure
REQ-035 Package spi_pkg SHALL hold the state enum, FRAME_BITS=16, HEADER_BITS=8, RW_BIT=15 and ADDR_W=7/DATA_W=8, shared with the spi initiator.
REQ-036 Sub-module spi_sync (SYNC_STAGES flops plus rise/fall edge outputs) SHALL be instantiated for SEN, SCK and SDAT.
REQ-037 Size: the FSM plus shift registers SHALL occupy 120-400 lines of RTL.

Verification
REQ-038 Write frame addr 0x15 data 0xA5, SCK half=15 clocks -> exactly one o_regWrStrobe, o_regAddr=0x15, o_regWrData=0xA5, no error.
REQ-039 Read frame addr 0x7F, i_regRdData=0x3C -> one o_regRdStrobe; bits sampled at SCK rises 9-16 = 0,0,1,1,1,1,0,0.
REQ-040 Write frame with SEN raised after 12 SCK rises -> no write strobe, one o_frameError pulse, o_busy falls.
REQ-041 Reset pulsed at bit 5 of a write, SEN held low through the frame end -> no strobe and no error; the next full frame is accepted.
REQ-042 Two write frames with SEN high for SYNC_STAGES+2 cycles between them, plus a 20-rise write frame -> two correct strobes; the 4 extra rises are ignored.
REQ-043 SCK_MIN_HALF=3 read at addr 0x00 with i_regRdData=0x80 -> MSB=1 valid at the 9th rise.
